// File: rtl/key_action_if.sv
// key_action_if: key-event inputs and decoded action outputs of key_action_map.
interface key_action_if #(
  parameter int N_ACT  = 3,
  parameter int CODE_W = 9
);
  logic              key_valid;
  logic              key_state;
  logic [CODE_W-1:0] key_code;
  logic              tick;
  logic [N_ACT-1:0]  held;
  logic [N_ACT-1:0]  act;
  logic [N_ACT-1:0]  press_evt;
  logic [N_ACT-1:0]  release_evt;
  logic              unknown_code;
  modport master (
    output key_valid, key_state, key_code, tick,
    input  held, act, press_evt, release_evt, unknown_code
  );
  modport slave (
    input  key_valid, key_state, key_code, tick,
    output held, act, press_evt, release_evt, unknown_code
  );
endinterface

// File: rtl/key_action_map.sv
// key_action_map: key make/break events to held/act state, per-tick edge pulses, SOCD resolution.
// Optional stuck-key watchdog enabled by defining KEY_ACTION_WATCHDOG_EN.
module key_action_map #(
  parameter int                      N_ACT        = 3,
  parameter int                      CODE_W       = 9,
  parameter logic [N_ACT*CODE_W-1:0] ACT_CODES    = {9'd87, 9'd68, 9'd65},
  parameter int                      SOCD_MODE    = 2,
  parameter int                      SOCD_A       = 0,
  parameter int                      SOCD_B       = 1,
  parameter logic [23:0]             HOLD_TIMEOUT = 24'd10_000_000
) (
  input logic        clk,
  input logic        rst,
  key_action_if.slave kif
);
  logic [N_ACT-1:0] hit, expire, held_d, held_q, act_d, act_q, pe, re;
  logic [N_ACT-1:0] press_acc_d, press_acc_q, release_acc_d, release_acc_q;
  logic [N_ACT-1:0] press_evt_d, press_evt_q, release_evt_d, release_evt_q;
  logic             unk_d, unk_q, last_d, last_q, both;
  always_comb begin
    for (int i = 0; i < N_ACT; i++)
      hit[i] = kif.key_valid && kif.key_code == ACT_CODES[i*CODE_W +: CODE_W];
  end
`ifdef KEY_ACTION_WATCHDOG_EN
  localparam int WD_W = $clog2(HOLD_TIMEOUT + 1);
  logic [N_ACT-1:0][WD_W-1:0] wd_d, wd_q;
  // Expiry lands on the edge where the count would reach HOLD_TIMEOUT, so held stays up exactly that many cycles.
  always_comb begin
    for (int i = 0; i < N_ACT; i++) begin
      expire[i] = held_q[i] && !hit[i] && wd_q[i] == WD_W'(HOLD_TIMEOUT - 24'd1);
      wd_d[i]   = (hit[i] || !held_q[i] || expire[i]) ? '0 : wd_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
`else
  assign expire = '0;
`endif
  always_comb begin
    for (int i = 0; i < N_ACT; i++)
      held_d[i] = hit[i] ? kif.key_state : held_q[i] && !expire[i];
  end
  assign pe            = held_d & ~held_q;
  assign re            = held_q & ~held_d;
  assign press_acc_d   = kif.tick ? '0 : press_acc_q | pe;
  assign release_acc_d = kif.tick ? '0 : release_acc_q | re;
  assign press_evt_d   = kif.tick ? press_acc_q | pe : '0;
  assign release_evt_d = kif.tick ? release_acc_q | re : '0;
  assign unk_d         = kif.key_valid && hit == '0;
  assign last_d        = pe[SOCD_A] ? 1'b0 : pe[SOCD_B] ? 1'b1 : last_q;
  assign both          = held_d[SOCD_A] && held_d[SOCD_B];
  // last_q = 1 means channel B pressed most recently.
  always_comb begin
    act_d = held_d;
    if (both && SOCD_MODE == 1) begin
      act_d[SOCD_A] = 1'b0;
      act_d[SOCD_B] = 1'b0;
    end else if (both && SOCD_MODE == 2) begin
      act_d[SOCD_A] = !last_d;
      act_d[SOCD_B] = last_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q        <= '0;
      act_q         <= '0;
      press_acc_q   <= '0;
      release_acc_q <= '0;
      press_evt_q   <= '0;
      release_evt_q <= '0;
      unk_q         <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      held_q        <= held_d;
      act_q         <= act_d;
      press_acc_q   <= press_acc_d;
      release_acc_q <= release_acc_d;
      press_evt_q   <= press_evt_d;
      release_evt_q <= release_evt_d;
      unk_q         <= unk_d;
      last_q        <= last_d;
    end
  end
  assign kif.held         = held_q;
  assign kif.act          = act_q;
  assign kif.press_evt    = press_evt_q;
  assign kif.release_evt  = release_evt_q;
  assign kif.unknown_code = unk_q;
endmodule

// File: tb/tb_key_action_map.sv
// tb_key_action_map: directed + random events on SOCD mode 1 and mode 2 instances vs a behavioural model.
module tb_key_action_map;
  localparam int N = 3;
  localparam int W = 9;
`ifdef KEY_ACTION_WATCHDOG_EN
  localparam logic [23:0] TO = 24'd100;
`else
  localparam logic [23:0] TO = 24'd10_000_000;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  key_action_if #(.N_ACT(N), .CODE_W(W)) if1 ();
  key_action_if #(.N_ACT(N), .CODE_W(W)) if2 ();
  key_action_map #(.SOCD_MODE(1), .HOLD_TIMEOUT(TO)) u_dut1 (.clk(clk), .rst(rst), .kif(if1.slave));
  key_action_map #(.SOCD_MODE(2), .HOLD_TIMEOUT(TO)) u_dut2 (.clk(clk), .rst(rst), .kif(if2.slave));
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int codes [N] = '{65, 68, 87};
  int refresh [N];
  logic [N-1:0] m_held, m_pacc, m_racc, m_pevt, m_revt, m_act1, m_act2;
  logic         m_unk;
  int           m_last;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic model_reset();
    m_held = '0; m_pacc = '0; m_racc = '0; m_pevt = '0; m_revt = '0;
    m_act1 = '0; m_act2 = '0; m_unk = 1'b0; m_last = 0;
  endtask
  task automatic model(input bit v, input bit s, input int code, input bit t);
    logic [N-1:0] nh, pe, re;
    bit matched = 0;
    nh = m_held;
    for (int i = 0; i < N; i++) begin
      if (v && code == codes[i]) begin
        matched = 1;
        nh[i] = s;
        if (s) refresh[i] = cyc;
      end
`ifdef KEY_ACTION_WATCHDOG_EN
      else if (m_held[i] && cyc - refresh[i] == int'(TO)) nh[i] = 1'b0;
`endif
    end
    pe = nh & ~m_held;
    re = m_held & ~nh;
    m_pevt = t ? (m_pacc | pe) : '0;
    m_revt = t ? (m_racc | re) : '0;
    m_pacc = t ? '0 : (m_pacc | pe);
    m_racc = t ? '0 : (m_racc | re);
    if (pe[0]) m_last = 0;
    else if (pe[1]) m_last = 1;
    m_held = nh;
    m_unk  = v && !matched;
    m_act1 = nh;
    m_act2 = nh;
    if (nh[0] && nh[1]) begin
      m_act1[1:0] = 2'b00;
      m_act2[1:0] = (m_last == 1) ? 2'b10 : 2'b01;
    end
  endtask
  task automatic check_all();
    check("held",    32'(if2.held),         32'(m_held));
    check("held_m1", 32'(if1.held),         32'(m_held));
    check("act_m1",  32'(if1.act),          32'(m_act1));
    check("act_m2",  32'(if2.act),          32'(m_act2));
    check("press",   32'(if2.press_evt),    32'(m_pevt));
    check("release", 32'(if2.release_evt),  32'(m_revt));
    check("unknown", 32'(if2.unknown_code), 32'(m_unk));
  endtask
  task automatic step(input bit v, input bit s, input int code, input bit t);
    if1.key_valid = v; if1.key_state = s; if1.key_code = W'(code); if1.tick = t;
    if2.key_valid = v; if2.key_state = s; if2.key_code = W'(code); if2.tick = t;
    @(posedge clk);
    cyc++;
    model(v, s, code, t);
    @(negedge clk);
    check_all();
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_held",  32'(if2.held),                           32'd0);
    check("rst_act",   32'(if1.act | if2.act),                  32'd0);
    check("rst_pulse", 32'(if2.press_evt | if2.release_evt),    32'd0);
    check("rst_unk",   32'(if2.unknown_code),                   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    if1.key_valid = 0; if1.key_state = 0; if1.key_code = '0; if1.tick = 0;
    if2.key_valid = 0; if2.key_state = 0; if2.key_code = '0; if2.tick = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    step(1, 1, 65, 0); idle(2); step(0, 0, 0, 1); idle(1);
    step(1, 0, 65, 0); idle(1); step(0, 0, 0, 1); idle(2);
    step(1, 1, 65, 0); step(1, 1, 68, 0); idle(1); step(1, 0, 68, 0); step(1, 0, 65, 0);
    step(0, 0, 0, 1); idle(1);
    repeat (5) begin step(1, 1, 87, 0); idle(1); end
    step(1, 0, 87, 0); step(0, 0, 0, 1); idle(1);
    step(1, 1, 88, 0); step(1, 0, 88, 0); idle(1);
    step(1, 1, 68, 1); idle(2); step(0, 0, 0, 1); step(1, 0, 68, 0); step(0, 0, 0, 1);
    step(1, 1, 68, 0); step(1, 1, 65, 0); step(1, 0, 65, 0); idle(1);
    step(1, 0, 68, 0); idle(1);
    step(1, 1, 87, 0);
    async_reset();
    check_all();
    step(0, 0, 0, 1); idle(2);
`ifdef KEY_ACTION_WATCHDOG_EN
    step(1, 1, 65, 0); idle(49); step(1, 1, 65, 0); idle(110);
    step(0, 0, 0, 1); idle(2);
`endif
    for (int k = 0; k < 3000; k++) begin
      int code;
      case ($urandom_range(0, 4))
        0: code = 65;
        1: code = 68;
        2: code = 87;
        3: code = 88;
        default: code = int'($urandom_range(0, 511));
      endcase
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), code, $urandom_range(0, 7) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
